i2s_stream_core: RTL and testbench

Parametrised I2S audio datapath for the codec interface: captures stereo ADC samples from the codec-mastered bit stream, applies a selectable channel mode, and serialises the result back to the DAC. Everything runs in the CLOCK_50 domain, with the codec clocks treated as oversampled data. It also generates the codec master clock. It sits directly under the board top level, between the AUD_* pins and any future effects stage, which taps the parallel sample outputs.

---
 rtl/i2s_stream_core.sv | 221 ++++++++++++++++++++++
 tb/tb_i2s_stream_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_stream_core.sv
// i2s_stream_core: oversampled I2S capture, channel mode and DAC
// serialiser, plus codec master clock, all in the CLOCK_50 domain.
//
// Ports:
//   CLOCK_50, reset          system clock, async active-high reset
//   AUD_BCLK/ADCLRCK/ADCDAT  codec-mastered ADC stream (sampled)
//   AUD_DACLRCK, AUD_DACDAT  DAC stream back to the codec
//   AUD_XCK                  codec master clock (CLOCK_50/XCK_DIV)
//   enable, mode             mute/valid gate; 00 pass 01 mute 10 swap 11 mono
//   left_sample/right_sample last good L/R pair, sample_valid pulse
//   frame_error              sticky short half-frame flag

module i2s_stream_core #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SYNC_STAGES  = 2,
  parameter int XCK_DIV      = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    AUD_BCLK,
  input  logic                    AUD_ADCLRCK,
  input  logic                    AUD_ADCDAT,
  output logic                    AUD_DACLRCK,
  output logic                    AUD_DACDAT,
  output logic                    AUD_XCK,
  input  logic                    enable,
  input  logic [1:0]              mode,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    sample_valid,
  output logic                    frame_error
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam int XW = $clog2(XCK_DIV);
  localparam logic [XW-1:0] XHALF = XW'(XCK_DIV / 2 - 1);
  localparam logic [CW-1:0] CMAX  = CW'(W);

  // ---------------- master clock ----------------
  logic [XW-1:0] xck_cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      xck_cnt <= '0;
      AUD_XCK <= 1'b0;
    end else if (xck_cnt == XHALF) begin
      xck_cnt <= '0;
      AUD_XCK <= ~AUD_XCK;
    end else begin
      xck_cnt <= xck_cnt + XW'(1);
    end
  end

  // ---------------- synchronisers ----------------
  logic [SYNC_STAGES-1:0] bclk_sr;
  logic [SYNC_STAGES-1:0] lrck_sr;
  logic [SYNC_STAGES-1:0] dat_sr;
  logic                   bclk_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bclk_sr <= '0;
      lrck_sr <= '0;
      dat_sr  <= '0;
      bclk_d  <= 1'b0;
    end else begin
      bclk_sr <= {bclk_sr[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sr <= {lrck_sr[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sr  <= {dat_sr[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_d  <= bclk_sr[SYNC_STAGES-1];
    end
  end

  logic bclk_s;
  logic lrck_s;
  logic dat_s;
  logic bclk_rise;
  logic bclk_fall;
  logic lrck_prev;
  logic boundary;

  assign bclk_s    = bclk_sr[SYNC_STAGES-1];
  assign lrck_s    = lrck_sr[SYNC_STAGES-1];
  assign dat_s     = dat_sr[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_d;
  assign bclk_fall = ~bclk_s & bclk_d;
  assign boundary  = bclk_rise & (lrck_s != lrck_prev);

  // ---------------- receive ----------------
  logic [CW-1:0] bit_cnt;
  logic [W-1:0]  rx_sr;
  logic [W-1:0]  hold_l;
  logic [W-1:0]  tx_left;
  logic [W-1:0]  tx_right;
  logic [W-1:0]  tx_l_nxt;
  logic [W-1:0]  tx_r_nxt;
  logic [W:0]    mono_sum;
  logic          synced;
  logic          left_ok;
  logic          live;
  logic          full;

  // A disabled block behaves as unsynced the moment enable drops.
  assign live = synced & enable;
  assign full = (bit_cnt == CMAX);

  // Mode applied to the pair just completed: hold_l and the
  // right word still sitting in the shift register.
  always_comb begin
    tx_l_nxt = hold_l;
    tx_r_nxt = rx_sr;
    mono_sum = {hold_l[W-1], hold_l} + {rx_sr[W-1], rx_sr};
    unique case (mode)
      2'b01: begin
        tx_l_nxt = '0;
        tx_r_nxt = '0;
      end
      2'b10: begin
        tx_l_nxt = rx_sr;
        tx_r_nxt = hold_l;
      end
      2'b11: begin
        tx_l_nxt = W'(mono_sum >> 1);
        tx_r_nxt = W'(mono_sum >> 1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bit_cnt      <= '0;
      rx_sr        <= '0;
      hold_l       <= '0;
      lrck_prev    <= 1'b0;
      synced       <= 1'b0;
      left_ok      <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      tx_left      <= '0;
      tx_right     <= '0;
      AUD_DACLRCK  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      AUD_DACLRCK  <= lrck_s;
      if (!enable) begin
        synced <= 1'b0;
      end
      if (bclk_rise) begin
        lrck_prev <= lrck_s;
        if (boundary) begin
          bit_cnt <= '0;
          if (lrck_s) begin
            // left half finished
            if (!live) begin
              left_ok <= 1'b0;
              if (enable) begin
                synced <= 1'b1;
              end
            end else if (full) begin
              hold_l  <= rx_sr;
              left_ok <= 1'b1;
            end else begin
              frame_error <= 1'b1;
              left_ok     <= 1'b0;
            end
          end else if (live) begin
            // right half finished: pair completion
            if (!full) begin
              frame_error <= 1'b1;
            end else if (left_ok) begin
              left_sample  <= hold_l;
              right_sample <= rx_sr;
              sample_valid <= 1'b1;
              tx_left      <= tx_l_nxt;
              tx_right     <= tx_r_nxt;
            end
          end
        end else if (!full) begin
          rx_sr   <= {rx_sr[W-2:0], dat_s};
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  // ---------------- transmit ----------------
  logic [W-1:0]  tx_sr;
  logic [CW-1:0] tx_cnt;

  // The load at a boundary sees tx_left/tx_right before any pair
  // update on the same strobe, so a new pair goes out next frame.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tx_sr      <= '0;
      tx_cnt     <= '0;
      AUD_DACDAT <= 1'b0;
    end else begin
      if (boundary) begin
        tx_sr  <= lrck_s ? tx_right : tx_left;
        tx_cnt <= '0;
      end else if (bclk_fall) begin
        if (tx_cnt != CMAX) begin
          AUD_DACDAT <= tx_sr[W-1];
          tx_sr      <= {tx_sr[W-2:0], 1'b0};
          tx_cnt     <= tx_cnt + CW'(1);
        end else begin
          AUD_DACDAT <= 1'b0;
        end
      end
      if (!enable) begin
        AUD_DACDAT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_stream_core.sv
// tb_i2s_stream_core: codec-side stimulus with a behavioural
// model, pair scoreboard and independent DAC word receiver.

module tb_i2s_stream_core;

  localparam int SW = 24;
  localparam int SS = 2;
  localparam int XD = 4;
  localparam int HB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          bclk;
  logic          lrck;
  logic          adcdat;
  logic          daclrck;
  logic          dacdat;
  logic          xck;
  logic          en;
  logic [1:0]    mode;
  logic [SW-1:0] ls;
  logic [SW-1:0] rs;
  logic          sv;
  logic          ferr;

  always #10 clk = ~clk;

  i2s_stream_core #(
    .SAMPLE_WIDTH(SW),
    .SYNC_STAGES (SS),
    .XCK_DIV     (XD)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .AUD_BCLK    (bclk),
    .AUD_ADCLRCK (lrck),
    .AUD_ADCDAT  (adcdat),
    .AUD_DACLRCK (daclrck),
    .AUD_DACDAT  (dacdat),
    .AUD_XCK     (xck),
    .enable      (en),
    .mode        (mode),
    .left_sample (ls),
    .right_sample(rs),
    .sample_valid(sv),
    .frame_error (ferr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } pair_t;

  typedef struct {
    bit            chk;
    logic [SW-1:0] w;
  } dac_t;

  pair_t pair_q[$];
  dac_t  dac_q[$];

  // model state
  bit            m_sync = 0;
  bit            m_lok  = 0;
  bit            m_ferr = 0;
  logic [SW-1:0] m_hl   = '0;
  logic [SW-1:0] m_txl  = '0;
  logic [SW-1:0] m_txr  = '0;
  bit            p_ch   = 0;
  logic [SW-1:0] p_w    = '0;
  int            p_nb   = 0;

  function automatic void chk(string nm,
                              logic [63:0] got,
                              logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endfunction

  function automatic longint sval(logic [SW-1:0] a);
    longint v;
    v = longint'(a);
    if (a[SW-1]) v = v - (longint'(1) << SW);
    return v;
  endfunction

  function automatic logic [SW-1:0] mono(logic [SW-1:0] a,
                                         logic [SW-1:0] b);
    longint s;
    s = (sval(a) + sval(b)) >>> 1;
    return SW'(s);
  endfunction

  function automatic logic [SW-1:0] rnd();
    return SW'($urandom);
  endfunction

  // A half-frame of channel ch with nb bit clocks has just ended.
  function automatic void model_end(bit ch,
                                    logic [SW-1:0] w,
                                    int nb);
    bit ok;
    ok = (nb - 1) >= SW;
    if (!(m_sync && en)) begin
      if (ch == 1'b0 && en) m_sync = 1;
      m_lok = 0;
      return;
    end
    if (!ok) begin
      m_ferr = 1;
      if (ch == 1'b0) m_lok = 0;
      return;
    end
    if (ch == 1'b0) begin
      m_hl  = w;
      m_lok = 1;
    end else if (m_lok) begin
      pair_q.push_back('{m_hl, w});
      case (mode)
        2'b00: begin m_txl = m_hl; m_txr = w; end
        2'b01: begin m_txl = '0; m_txr = '0; end
        2'b10: begin m_txl = w; m_txr = m_hl; end
        default: begin
          m_txl = mono(m_hl, w);
          m_txr = m_txl;
        end
      endcase
    end
  endfunction

  function automatic void model_reset();
    m_sync = 0;
    m_lok  = 0;
    m_ferr = 0;
    m_hl   = '0;
    m_txl  = '0;
    m_txr  = '0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_left", ls, 0);
    chk("rst_right", rs, 0);
    chk("rst_valid", sv, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_dacdat", dacdat, 0);
    chk("rst_daclrck", daclrck, 0);
    rst = 1'b0;
  endtask

  task automatic send_half(bit ch, logic [SW-1:0] w,
                           int nb, int rst_at);
    dac_t e;
    e.chk = (rst_at < 0) && (nb > SW);
    e.w   = en ? (ch ? m_txr : m_txl) : '0;
    dac_q.push_back(e);
    if (ch != p_ch) model_end(p_ch, p_w, p_nb);
    for (int i = 0; i < nb; i++) begin
      bclk = 1'b0;
      lrck = ch;
      if (i >= 1 && i <= SW) adcdat = w[SW-i];
      else adcdat = 1'($urandom);
      repeat (HB) @(negedge clk);
      bclk = 1'b1;
      if (i == rst_at) do_reset();
      repeat (HB) @(negedge clk);
    end
    p_ch = ch;
    p_w  = w;
    p_nb = nb;
  endtask

  task automatic send_frame(logic [SW-1:0] l,
                            logic [SW-1:0] r, int nb);
    send_half(1'b0, l, nb, -1);
    send_half(1'b1, r, nb, -1);
  endtask

  task automatic set_enable(logic v);
    en = v;
    if (!v) m_sync = 0;
  endtask

  // pair scoreboard
  always @(negedge clk) begin
    pair_t p;
    if (sv === 1'b1) begin
      if (pair_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sample_valid: unexpected pulse L=%h R=%h",
                 ls, rs);
      end else begin
        p = pair_q.pop_front();
        chk("left_sample", ls, p.l);
        chk("right_sample", rs, p.r);
      end
    end
  end

  // DAC receiver: slot 0 at an LRCK change, bits in slots 1..SW
  bit            r_lr   = 0;
  int            r_slot = 0;
  logic [SW-1:0] r_acc  = '0;

  always @(posedge bclk) begin
    dac_t e;
    if (lrck != r_lr) begin
      r_lr = lrck;
      if (dac_q.size() > 0) begin
        e = dac_q.pop_front();
        if (e.chk && r_slot >= SW) chk("dac_word", r_acc, e.w);
      end
      r_slot = 0;
    end else begin
      if (r_slot < 64) r_slot++;
      if (r_slot <= SW) r_acc = {r_acc[SW-2:0], dacdat};
    end
  end

  initial begin
    rst    = 1'b1;
    bclk   = 1'b0;
    lrck   = 1'b0;
    adcdat = 1'b0;
    en     = 1'b1;
    mode   = 2'b00;
    repeat (4) @(negedge clk);
    chk("rst_xck", xck, 0);
    chk("rst_left", ls, 0);
    chk("rst_right", rs, 0);
    chk("rst_valid", sv, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_dacdat", dacdat, 0);
    chk("rst_daclrck", daclrck, 0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("xck", xck, (k / 2) % 2);
    end

    send_frame(rnd(), rnd(), 32);
    send_frame(24'h123456, 24'hABCDEF, 32);
    repeat (3) send_frame(rnd(), rnd(), 32);

    mode = 2'b11;
    send_frame(24'h400000, 24'h200000, 32);
    send_frame(24'h7FFFFF, 24'h800000, 32);
    send_frame(rnd(), rnd(), 32);
    mode = 2'b10;
    repeat (2) send_frame(rnd(), rnd(), 32);
    mode = 2'b01;
    repeat (2) send_frame(rnd(), rnd(), 32);
    mode = 2'b00;
    send_frame(rnd(), rnd(), 32);
    chk("ferr_clean", ferr, m_ferr);

    send_frame(rnd(), rnd(), 16);
    repeat (2) send_frame(rnd(), rnd(), 32);
    chk("ferr_sticky", ferr, m_ferr);
    chk("ferr_set", ferr, 1);

    send_half(1'b0, rnd(), 32, 10);
    send_half(1'b1, rnd(), 32, -1);
    repeat (2) send_frame(rnd(), rnd(), 32);
    chk("ferr_after_rst", ferr, m_ferr);

    set_enable(1'b0);
    repeat (2) send_frame(rnd(), rnd(), 32);
    set_enable(1'b1);
    mode = 2'(($urandom % 4));
    repeat (3) send_frame(rnd(), rnd(), 32);
    send_half(1'b0, rnd(), 32, -1);
    repeat (50) @(negedge clk);
    chk("pending_pairs", pair_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
